// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the instruction-fetch bus
// and the data bus. Each transaction is a single beat. The arbiter latches
// the winning request, holds the grant until the downstream response is
// complete, then returns the response to the bus that owns the grant.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a tie is
// won by the requester that did not own the previous grant. When it is not
// defined, the data bus always wins a tie.
//
// IDATA_W must equal DATA_W/2.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; if a request is present, pick a winner and latch it
// BUSY  | creq_* presented from the latched copy until the last beat returns
// RESP  | one-cycle addr_ok/data_ok pulse to the owner, then back to IDLE

module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int IDATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    output logic                  iresp_addr_ok,
    output logic                  iresp_data_ok,
    output logic [IDATA_W-1:0]    iresp_data,

    input  logic                  dreq_valid,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [2:0]            dreq_size,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    input  logic [DATA_W-1:0]     dreq_data,
    output logic                  dresp_addr_ok,
    output logic                  dresp_data_ok,
    output logic [DATA_W-1:0]     dresp_data,

    output logic                  creq_valid,
    output logic                  creq_is_write,
    output logic [2:0]            creq_size,
    output logic [ADDR_W-1:0]     creq_addr,
    output logic [DATA_W/8-1:0]   creq_strobe,
    output logic [DATA_W-1:0]     creq_data,
    input  logic                  cresp_ready,
    input  logic                  cresp_last,
    input  logic [DATA_W-1:0]     cresp_data
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t               state, state_nx;
    owner_t               owner;
    logic                 req_any;
    logic                 grant_data;
    logic                 beat_done;

    logic                 req_is_write;
    logic [2:0]           req_size;
    logic [ADDR_W-1:0]    req_addr;
    logic [STRB_W-1:0]    req_strobe;
    logic [DATA_W-1:0]    req_data;
    logic [DATA_W-1:0]    rdata;

    assign req_any   = ireq_valid | dreq_valid;
    assign beat_done = cresp_ready & cresp_last;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    // Tie goes to whoever did not hold the previous grant; a lone requester always wins.
    always_comb begin
        grant_data = dreq_valid;
        if (dreq_valid && ireq_valid) begin
            grant_data = (last_owner == OWN_INSTR);
        end
    end

    // Remember who was served, recorded as the response is handed back.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_INSTR;
        end else if (state == RESP) begin
            last_owner <= owner;
        end
    end
`else
    // Fixed priority: a memory-stage stall blocks the whole pipeline, so data wins.
    always_comb begin
        grant_data = dreq_valid;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> BUSY -> RESP -> IDLE, no grant straight out of RESP.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any)   state_nx = BUSY;
            BUSY:    if (beat_done) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the winner's request in IDLE so later input changes cannot disturb the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner        <= OWN_INSTR;
            req_is_write <= 1'b0;
            req_size     <= 3'b000;
            req_addr     <= '0;
            req_strobe   <= '0;
            req_data     <= '0;
        end else if (state == IDLE && req_any) begin
            if (grant_data) begin
                owner        <= OWN_DATA;
                req_is_write <= |dreq_strobe;
                req_size     <= dreq_size;
                req_addr     <= dreq_addr;
                req_strobe   <= dreq_strobe;
                req_data     <= dreq_data;
            end else begin
                owner        <= OWN_INSTR;
                req_is_write <= 1'b0;
                req_size     <= 3'b010;
                req_addr     <= ireq_addr;
                req_strobe   <= '0;
                req_data     <= '0;
            end
        end
    end

    // Hold the returned beat for the response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (state == BUSY && beat_done) begin
            rdata <= cresp_data;
        end
    end

    // Output decode. Responses are gated by the owner's valid, so a requester
    // that gave up mid-transaction gets no pulse even though the beat completed.
    always_comb begin
        creq_valid    = 1'b0;
        creq_is_write = 1'b0;
        creq_size     = 3'b000;
        creq_addr     = '0;
        creq_strobe   = '0;
        creq_data     = '0;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        case (state)
            BUSY: begin
                creq_valid    = 1'b1;
                creq_is_write = req_is_write;
                creq_size     = req_size;
                creq_addr     = req_addr;
                creq_strobe   = req_strobe;
                creq_data     = req_data;
            end
            RESP: begin
                if (owner == OWN_INSTR && ireq_valid) begin
                    iresp_addr_ok = 1'b1;
                    iresp_data_ok = 1'b1;
                    iresp_data    = req_addr[2] ? rdata[DATA_W-1:IDATA_W]
                                                : rdata[IDATA_W-1:0];
                end
                if (owner == OWN_DATA && dreq_valid) begin
                    dresp_addr_ok = 1'b1;
                    dresp_data_ok = 1'b1;
                    dresp_data    = rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
